// File: rtl/imem_fill_server_pkg.sv
// Shared types and constants for the instruction-memory fill server.
// Holds the FSM state encoding, the NOP returned on bad addresses, and latency bounds.
package imem_fill_server_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam int          LAT_MIN  = 1;
    localparam int          LAT_MAX  = 7;

    // True when any byte-address bit above the RAM's word index is set.
    function automatic logic addr_oor(input logic [31:0] addr, input int abits);
        return (addr >> (abits + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/imem_fill_server_bram.sv
// Synchronous-read instruction RAM with one read and one write port.
// A write to the word being read on the same edge is forwarded to the read data.
module imem_bram #(
    parameter int ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [31:0]          rd_data_o,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [31:0]          wr_data_i
);

    logic [31:0] mem [2**ADDR_BITS];
    logic [31:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    end

    // Only the output register is reset; the array keeps the program image.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data_q <= '0;
        else if (rd_en_i)
            rd_data_q <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_fill_server.sv
// Instruction-cache fill responder: one word request at a time, fixed latency,
// abortable on flush, with a loader write port into the shared RAM.
module imem_fill_server
    import imem_fill_server_pkg::*;
#(
    parameter int ADDR_BITS = 14,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic [31:0] req_addr_i,
    output logic        req_ready_o,
    input  logic        abort_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic [31:0] rsp_addr_o,
    output logic        rsp_err_o,
    input  logic        wr_en_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i
);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("imem_fill_server: LATENCY must be within 1..7");
    end
    if (ADDR_BITS < 1 || ADDR_BITS > 30) begin : g_bad_addr_bits
        $error("imem_fill_server: ADDR_BITS must be within 1..30");
    end

    localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic [31:0] rsp_addr_q;
    logic        rsp_err_q;

    logic        accept;
    logic        rd_fire;
    logic [31:0] rd_addr;
    logic        rd_oor;
    logic        wr_oor;
    logic [31:0] bram_rd_data;
    logic        unused_wr_lsb;

    assign unused_wr_lsb = ^wr_addr_i[1:0];

    assign req_ready_o = ((state_q == IDLE) || (state_q == RESP)) && !abort_i;
    assign accept      = req_valid_i && req_ready_o;
    assign rsp_valid_o = (state_q == RESP) && !abort_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // With single-cycle latency the read launches straight off the accepting request.
    assign rd_fire = (LATENCY == 1) ? accept
                                    : ((state_q == WAIT) && (cnt_q == 3'd1) && !abort_i);
    assign rd_addr = (LATENCY == 1) ? req_addr_i : addr_q;
    assign rd_oor  = addr_oor(rd_addr, ADDR_BITS);
    assign wr_oor  = addr_oor(wr_addr_i, ADDR_BITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rsp_addr_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) addr_q <= req_addr_i;
            if (rd_fire) begin
                rsp_addr_q <= rd_addr;
                rsp_err_q  <= rd_oor;
            end
        end
    end

    imem_bram #(.ADDR_BITS(ADDR_BITS)) u_bram (
        .clk       (clk),
        .rst       (rst),
        .rd_en_i   (rd_fire && !rd_oor),
        .rd_addr_i (rd_addr[ADDR_BITS+1:2]),
        .rd_data_o (bram_rd_data),
        .wr_en_i   (wr_en_i && !wr_oor),
        .wr_addr_i (wr_addr_i[ADDR_BITS+1:2]),
        .wr_data_i (wr_data_i)
    );

    assign rsp_data_o = rsp_err_q ? NOP_INSN : bram_rd_data;
    assign rsp_addr_o = rsp_addr_q;
    assign rsp_err_o  = rsp_err_q;

endmodule

// File: tb/tb_imem_fill_server.sv
// Directed bench for imem_fill_server: LATENCY=2 instance checked through a
// response scoreboard plus cycle-exact strobes, and a LATENCY=1 instance.
module tb_imem_fill_server;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] a;
        logic        e;
    } exp_t;

    logic        clk, rst;
    logic        req_valid, req_ready, abort;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data, rsp_addr;
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;

    logic        req_valid1, req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] req_addr1, rsp_data1, rsp_addr1;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [31:0] mm [logic [13:0]];

    imem_fill_server #(.ADDR_BITS(14), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
        .abort_i(abort),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_addr_o(rsp_addr), .rsp_err_o(rsp_err),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
    );

    imem_fill_server #(.ADDR_BITS(14), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid1), .req_addr_i(req_addr1), .req_ready_o(req_ready1),
        .abort_i(abort),
        .rsp_valid_o(rsp_valid1), .rsp_data_o(rsp_data1), .rsp_addr_o(rsp_addr1), .rsp_err_o(rsp_err1),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic exp_t expect_for(input logic [31:0] a);
        exp_t x;
        x.a = a;
        x.e = (a[31:16] != 16'd0);
        x.d = x.e ? 32'h0000_0013 : mm[a[15:2]];
        return x;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        if (a[31:16] == 16'd0) mm[a[15:2]] = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Isolated request on the LATENCY=2 instance with strobe timing checks.
    task automatic one_req(input string tag, input logic [31:0] a);
        req_valid = 1'b1; req_addr = a;
        mid(); chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        sb.push_back(expect_for(a));
        tick();
        req_valid = 1'b0;
        mid(); chk({tag, "_vld_c1"}, 32'(rsp_valid), 32'd0);
        tick();
        mid(); chk({tag, "_vld_c2"}, 32'(rsp_valid), 32'd1);
        tick();
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            exp_t x;
            chk("sb_has_expect", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("sb_data", rsp_data, x.d);
                chk("sb_addr", rsp_addr, x.a);
                chk("sb_err", 32'(rsp_err), 32'(x.e));
            end
        end
    end

    initial begin
        logic [31:0] addrs [3];
        logic [31:0] a;
        int k;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; abort = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid1 = 1'b0; req_addr1 = '0;
        tick();
        mid();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_vld", 32'(rsp_valid), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_addr", rsp_addr, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst1_ready", 32'(req_ready1), 32'd1);
        chk("rst1_data", rsp_data1, 32'd0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) wr(32'(i * 4), 32'hA500_0000 + 32'(i) * 32'h111);
        wr(32'h10, 32'hDEAD_BEEF);

        // basic request
        one_req("t1", 32'h10);
        mid(); chk("t1_vld_c3", 32'(rsp_valid), 32'd0);
        chk("t1_hold_data", rsp_data, 32'hDEAD_BEEF);
        tick();

        // back-to-back with req_valid held
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            logic rdy_e, vld_e;
            rdy_e = (c % 2 == 0) || (c == 7);
            vld_e = (c == 2) || (c == 4) || (c == 6);
            req_valid = (k < 3);
            if (k < 3) req_addr = addrs[k];
            mid();
            chk($sformatf("t2_ready_c%0d", c), 32'(req_ready), 32'(rdy_e));
            chk($sformatf("t2_vld_c%0d", c), 32'(rsp_valid), 32'(vld_e));
            if (k < 3 && rdy_e) begin
                sb.push_back(expect_for(addrs[k]));
                k++;
            end
            tick();
        end
        req_valid = 1'b0;

        // abort while waiting
        req_valid = 1'b1; req_addr = 32'h14; mid(); tick();
        req_valid = 1'b0; abort = 1'b1;
        mid(); chk("t3_ready_in_abort", 32'(req_ready), 32'd0); tick();
        abort = 1'b0;
        mid(); chk("t3_vld_c2", 32'(rsp_valid), 32'd0); chk("t3_ready_c2", 32'(req_ready), 32'd1); tick();

        // abort in the response cycle, with a request that must not be taken
        req_valid = 1'b1; req_addr = 32'h18; mid(); tick();
        req_valid = 1'b0; mid(); tick();
        abort = 1'b1; req_valid = 1'b1; req_addr = 32'h1C;
        mid(); chk("t3b_vld_abort", 32'(rsp_valid), 32'd0); chk("t3b_ready_abort", 32'(req_ready), 32'd0); tick();
        abort = 1'b0; req_valid = 1'b0;
        mid(); chk("t3b_ready", 32'(req_ready), 32'd1); chk("t3b_vld1", 32'(rsp_valid), 32'd0); tick();
        mid(); chk("t3b_vld2", 32'(rsp_valid), 32'd0); tick();
        mid(); chk("t3b_vld3", 32'(rsp_valid), 32'd0); tick();

        // range boundaries; out-of-range write aliasing word 4 must be dropped
        wr(32'h0001_0010, 32'hBAD0_BAD0);
        wr(32'h0000_FFFC, 32'hCAFE_F00D);
        one_req("t4_oor", 32'h0001_0000);
        one_req("t4_oor_msb", 32'h8000_0000);
        one_req("t4_top", 32'h0000_FFFC);
        one_req("t4_lsb", 32'h0000_FFFF);
        one_req("t4_nodrop", 32'h10);

        // write to the word on the read edge is forwarded
        req_valid = 1'b1; req_addr = 32'h20;
        mid(); sb.push_back('{d: 32'h1234_5678, a: 32'h20, e: 1'b0}); tick();
        req_valid = 1'b0; wr_en = 1'b1; wr_addr = 32'h20; wr_data = 32'h1234_5678; mm[14'd8] = 32'h1234_5678;
        mid(); tick();
        wr_en = 1'b0;
        mid(); chk("t5_vld", 32'(rsp_valid), 32'd1); tick();

        // reset while waiting discards the request
        req_valid = 1'b1; req_addr = 32'h24; mid(); tick();
        req_valid = 1'b0; rst = 1'b1; mid(); tick();
        rst = 1'b0;
        mid();
        chk("t6_vld", 32'(rsp_valid), 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd1);
        chk("t6_data", rsp_data, 32'd0);
        chk("t6_addr", rsp_addr, 32'd0);
        chk("t6_err", 32'(rsp_err), 32'd0);
        tick();
        mid(); chk("t6_vld_late", 32'(rsp_valid), 32'd0); tick();
        one_req("t6_ram_kept", 32'h10);

        // back-to-back random traffic with loader writes during the wait cycle
        for (int n = 0; n < 12; n++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'h0002_0000 + 32'($urandom_range(0, 15) * 4)
                                             : 32'($urandom_range(0, 15) * 4);
            req_valid = 1'b1; req_addr = a;
            mid(); chk($sformatf("rnd_ready_%0d", n), 32'(req_ready), 32'd1); tick();
            req_valid = 1'b0;
            wr_en = 1'b1; wr_addr = 32'($urandom_range(0, 15) * 4); wr_data = $urandom;
            mm[wr_addr[15:2]] = wr_data;
            mid(); sb.push_back(expect_for(a)); tick();
            wr_en = 1'b0;
        end
        mid(); tick();
        mid(); tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // LATENCY=1 instance: response in the next cycle, back-to-back
        req_valid1 = 1'b1; req_addr1 = 32'h10;
        mid(); chk("l1_ready_c0", 32'(req_ready1), 32'd1); chk("l1_vld_c0", 32'(rsp_valid1), 32'd0); tick();
        req_addr1 = 32'h4;
        mid();
        chk("l1_vld_c1", 32'(rsp_valid1), 32'd1);
        chk("l1_data_c1", rsp_data1, mm[14'd4]);
        chk("l1_addr_c1", rsp_addr1, 32'h10);
        chk("l1_ready_c1", 32'(req_ready1), 32'd1);
        tick();
        req_addr1 = 32'h0004_0000;
        mid(); chk("l1_vld_c2", 32'(rsp_valid1), 32'd1); chk("l1_data_c2", rsp_data1, mm[14'd1]); tick();
        req_valid1 = 1'b0;
        mid();
        chk("l1_vld_oor", 32'(rsp_valid1), 32'd1);
        chk("l1_err_oor", 32'(rsp_err1), 32'd1);
        chk("l1_data_oor", rsp_data1, 32'h0000_0013);
        tick();
        mid(); chk("l1_vld_idle", 32'(rsp_valid1), 32'd0); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
